// File: rtl/sys_pkg.sv
// Shared definitions for the command sequencer: opcodes, FSM encoding, ALU function codes
// and default register-file operand addresses.
package sys_pkg;

    localparam logic [7:0] CmdRfWr    = 8'hAA;
    localparam logic [7:0] CmdRfRd    = 8'hBB;
    localparam logic [7:0] CmdAluOp   = 8'hCC;
    localparam logic [7:0] CmdAluNoOp = 8'hDD;

    localparam int unsigned OpaAddrDefault = 0;
    localparam int unsigned OpbAddrDefault = 1;
    localparam int unsigned TimeoutDefault = 255;
    localparam int unsigned WdCntWidth     = 8;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StWrAddr  = 4'd1,
        StWrData  = 4'd2,
        StRdAddr  = 4'd3,
        StRdWait  = 4'd4,
        StOpa     = 4'd5,
        StOpb     = 4'd6,
        StFun     = 4'd7,
        StAluWait = 4'd8,
        StTxRd    = 4'd9,
        StTxLsb   = 4'd10,
        StTxMsb   = 4'd11
    } state_e;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluMul   = 4'd2,
        AluDiv   = 4'd3,
        AluAnd   = 4'd4,
        AluOr    = 4'd5,
        AluNand  = 4'd6,
        AluNor   = 4'd7,
        AluXor   = 4'd8,
        AluXnor  = 4'd9,
        AluCmpEq = 4'd10,
        AluCmpGt = 4'd11,
        AluCmpLt = 4'd12,
        AluShr   = 4'd13,
        AluShra  = 4'd14
    } alu_fun_e;

    // States in which the sequencer is blocked on a response from the RF or the ALU.
    function automatic logic is_wait_state(input state_e st);
        return (st == StRdWait) || (st == StAluWait);
    endfunction

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Signal bundle between the command sequencer (master) and its RX, register-file, ALU and
// TX neighbours (slave).
interface sys_cmd_ctrl_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_FUN_WIDTH = 4
);

    logic [DATA_WIDTH-1:0]    rx_p_data;
    logic                     rx_d_vld;
    logic [ADDR_WIDTH-1:0]    rf_addr;
    logic [DATA_WIDTH-1:0]    rf_wr_data;
    logic                     rf_wr_en;
    logic                     rf_rd_en;
    logic [DATA_WIDTH-1:0]    rf_rd_data;
    logic                     rf_rd_data_vld;
    logic [ALU_FUN_WIDTH-1:0] alu_fun;
    logic                     alu_en;
    logic                     clk_gate_en;
    logic [2*DATA_WIDTH-1:0]  alu_out;
    logic                     alu_out_vld;
    logic [DATA_WIDTH-1:0]    tx_p_data;
    logic                     tx_d_vld;
    logic                     tx_ready;
    logic                     cmd_err;

    modport master (
        input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, tx_ready,
        output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, clk_gate_en,
        output tx_p_data, tx_d_vld, cmd_err
    );

    modport slave (
        output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, tx_ready,
        input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, clk_gate_en,
        input  tx_p_data, tx_d_vld, cmd_err
    );

endinterface

// File: rtl/sys_cmd_watchdog.sv
// Response timeout counter: held at zero while cleared, counts while enabled and saturates at
// LIMIT, flagging expiry for as long as it sits there enabled.
module sys_cmd_watchdog #(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned LIMIT     = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [CNT_WIDTH-1:0] LimitVal = CNT_WIDTH'(LIMIT);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_at_limit;

    assign w_at_limit = (r_count == LimitVal);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && w_at_limit;

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: parses AA/BB/CC/DD byte frames, drives RF and ALU strobes and returns read
// data or ALU results to the UART TX side over a valid/ready handshake.
module sys_cmd_ctrl
    import sys_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ALU_FUN_WIDTH  = 4,
    parameter int unsigned OPA_ADDR       = OpaAddrDefault,
    parameter int unsigned OPB_ADDR       = OpbAddrDefault,
    parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sys_cmd_ctrl_if.master io_bus
);

    localparam logic [ADDR_WIDTH-1:0] OpaAddr = ADDR_WIDTH'(OPA_ADDR);
    localparam logic [ADDR_WIDTH-1:0] OpbAddr = ADDR_WIDTH'(OPB_ADDR);

    state_e                   r_state,       w_state_nxt;
    logic [ADDR_WIDTH-1:0]    r_rf_addr,     w_rf_addr_nxt;
    logic [DATA_WIDTH-1:0]    r_rf_wr_data,  w_rf_wr_data_nxt;
    logic                     r_rf_wr_en,    w_rf_wr_en_nxt;
    logic                     r_rf_rd_en,    w_rf_rd_en_nxt;
    logic [ALU_FUN_WIDTH-1:0] r_alu_fun,     w_alu_fun_nxt;
    logic                     r_alu_en,      w_alu_en_nxt;
    logic                     r_clk_gate_en, w_clk_gate_en_nxt;
    logic [DATA_WIDTH-1:0]    r_tx_p_data,   w_tx_p_data_nxt;
    logic                     r_tx_d_vld,    w_tx_d_vld_nxt;
    logic                     r_cmd_err,     w_cmd_err_nxt;
    logic [2*DATA_WIDTH-1:0]  r_result,      w_result_nxt;

    logic                     w_rx_vld;
    logic [DATA_WIDTH-1:0]    w_frame;
    logic                     w_tx_hs;
    logic                     w_wd_en;
    logic                     w_wd_expire;

    assign w_rx_vld = io_bus.rx_d_vld;
    assign w_frame  = io_bus.rx_p_data;
    assign w_tx_hs  = r_tx_d_vld && io_bus.tx_ready;
    assign w_wd_en  = is_wait_state(r_state);

    // Holding the counter in clear outside the wait states restarts it on every entry.
    sys_cmd_watchdog #(
        .CNT_WIDTH (WdCntWidth),
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (!w_wd_en),
        .i_en     (w_wd_en),
        .o_expire (w_wd_expire)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_rf_addr_nxt     = r_rf_addr;
        w_rf_wr_data_nxt  = r_rf_wr_data;
        w_rf_wr_en_nxt    = 1'b0;
        w_rf_rd_en_nxt    = 1'b0;
        w_alu_fun_nxt     = r_alu_fun;
        w_alu_en_nxt      = 1'b0;
        w_clk_gate_en_nxt = r_clk_gate_en;
        w_tx_p_data_nxt   = r_tx_p_data;
        w_tx_d_vld_nxt    = r_tx_d_vld;
        w_cmd_err_nxt     = 1'b0;
        w_result_nxt      = r_result;

        unique case (r_state)
            StIdle: begin
                if (w_rx_vld) begin
                    case (w_frame)
                        CmdRfWr:    w_state_nxt   = StWrAddr;
                        CmdRfRd:    w_state_nxt   = StRdAddr;
                        CmdAluOp:   w_state_nxt   = StOpa;
                        CmdAluNoOp: w_state_nxt   = StFun;
                        default:    w_cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            StWrAddr: begin
                if (w_rx_vld) begin
                    w_rf_addr_nxt = w_frame[ADDR_WIDTH-1:0];
                    w_state_nxt   = StWrData;
                end
            end
            StWrData: begin
                if (w_rx_vld) begin
                    w_rf_wr_data_nxt = w_frame;
                    w_rf_wr_en_nxt   = 1'b1;
                    w_state_nxt      = StIdle;
                end
            end
            StRdAddr: begin
                if (w_rx_vld) begin
                    w_rf_addr_nxt  = w_frame[ADDR_WIDTH-1:0];
                    w_rf_rd_en_nxt = 1'b1;
                    w_state_nxt    = StRdWait;
                end
            end
            StRdWait: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (io_bus.rf_rd_data_vld) begin
                    w_tx_p_data_nxt = io_bus.rf_rd_data;
                    w_tx_d_vld_nxt  = 1'b1;
                    w_state_nxt     = StTxRd;
                end else if (w_wd_expire) begin
                    w_cmd_err_nxt = 1'b1;
                    w_state_nxt   = StIdle;
                end
                if (w_rx_vld) begin
                    w_cmd_err_nxt = 1'b1;
                end
            end
            StOpa: begin
                if (w_rx_vld) begin
                    w_rf_addr_nxt    = OpaAddr;
                    w_rf_wr_data_nxt = w_frame;
                    w_rf_wr_en_nxt   = 1'b1;
                    w_state_nxt      = StOpb;
                end
            end
            StOpb: begin
                if (w_rx_vld) begin
                    w_rf_addr_nxt    = OpbAddr;
                    w_rf_wr_data_nxt = w_frame;
                    w_rf_wr_en_nxt   = 1'b1;
                    w_state_nxt      = StFun;
                end
            end
            StFun: begin
                if (w_rx_vld) begin
                    w_alu_fun_nxt     = w_frame[ALU_FUN_WIDTH-1:0];
                    w_alu_en_nxt      = 1'b1;
                    w_clk_gate_en_nxt = 1'b1;
                    w_state_nxt       = StAluWait;
                end
            end
            StAluWait: begin
                if (io_bus.alu_out_vld) begin
                    w_result_nxt      = io_bus.alu_out;
                    w_tx_p_data_nxt   = io_bus.alu_out[DATA_WIDTH-1:0];
                    w_tx_d_vld_nxt    = 1'b1;
                    w_clk_gate_en_nxt = 1'b0;
                    w_state_nxt       = StTxLsb;
                end else if (w_wd_expire) begin
                    w_cmd_err_nxt     = 1'b1;
                    w_clk_gate_en_nxt = 1'b0;
                    w_state_nxt       = StIdle;
                end
                if (w_rx_vld) begin
                    w_cmd_err_nxt = 1'b1;
                end
            end
            StTxRd, StTxMsb: begin
                if (w_tx_hs) begin
                    w_tx_d_vld_nxt = 1'b0;
                    w_state_nxt    = StIdle;
                end
                if (w_rx_vld) begin
                    w_cmd_err_nxt = 1'b1;
                end
            end
            StTxLsb: begin
                if (w_tx_hs) begin
                    w_tx_p_data_nxt = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                    w_state_nxt     = StTxMsb;
                end
                if (w_rx_vld) begin
                    w_cmd_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_rf_addr     <= '0;
            r_rf_wr_data  <= '0;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_alu_fun     <= '0;
            r_alu_en      <= 1'b0;
            r_clk_gate_en <= 1'b0;
            r_tx_p_data   <= '0;
            r_tx_d_vld    <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_result      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rf_addr     <= w_rf_addr_nxt;
            r_rf_wr_data  <= w_rf_wr_data_nxt;
            r_rf_wr_en    <= w_rf_wr_en_nxt;
            r_rf_rd_en    <= w_rf_rd_en_nxt;
            r_alu_fun     <= w_alu_fun_nxt;
            r_alu_en      <= w_alu_en_nxt;
            r_clk_gate_en <= w_clk_gate_en_nxt;
            r_tx_p_data   <= w_tx_p_data_nxt;
            r_tx_d_vld    <= w_tx_d_vld_nxt;
            r_cmd_err     <= w_cmd_err_nxt;
            r_result      <= w_result_nxt;
        end
    end

    assign io_bus.rf_addr     = r_rf_addr;
    assign io_bus.rf_wr_data  = r_rf_wr_data;
    assign io_bus.rf_wr_en    = r_rf_wr_en;
    assign io_bus.rf_rd_en    = r_rf_rd_en;
    assign io_bus.alu_fun     = r_alu_fun;
    assign io_bus.alu_en      = r_alu_en;
    assign io_bus.clk_gate_en = r_clk_gate_en;
    assign io_bus.tx_p_data   = r_tx_p_data;
    assign io_bus.tx_d_vld    = r_tx_d_vld;
    assign io_bus.cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl: expected RF/ALU strobes, TX bytes and error pulses are
// queued by the stimulus and checked every cycle by a single compare process.
module tb_sys_cmd_ctrl;
    import sys_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned FW  = 4;
    localparam int          TMO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sys_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(FW)) bus ();

    sys_cmd_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .ALU_FUN_WIDTH  (FW),
        .OPA_ADDR       (0),
        .OPB_ADDR       (1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        q_wr[$];
    ev_t        q_rd[$];
    ev_t        q_alu[$];
    logic [7:0] q_tx[$];
    int         q_err[$];
    logic [7:0] mem[16];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a,
                                              input logic [7:0] b);
        case (f)
            AluAdd:  return 16'(a) + 16'(b);
            AluSub:  return 16'(a) - 16'(b);
            AluMul:  return 16'(a) * 16'(b);
            AluAnd:  return {8'h00, a & b};
            AluOr:   return {8'h00, a | b};
            AluXor:  return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    // Model-side effects of commands.
    function automatic void model_wr(input logic [3:0] a, input logic [7:0] d, input int c);
        q_wr.push_back('{c, a, d});
        mem[a] = d;
    endfunction

    // ---------------- compare process ----------------
    logic       rst_prev = 1'b1;
    logic       alu_vld_prev = 1'b0;
    logic       vld_prev = 1'b0;
    logic       rdy_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic       exp_gate = 1'b0;

    always @(negedge clk) begin : cmp
        ev_t e;
        if (!rst) begin
            chk("strobe_excl", 32'($countones({bus.rf_wr_en, bus.rf_rd_en, bus.alu_en}) <= 1), 1);

            if (bus.rf_wr_en) begin
                chk("rf_wr_expected", 32'(q_wr.size() != 0), 1);
                if (q_wr.size() != 0) begin
                    e = q_wr.pop_front();
                    chk("rf_wr_cycle", cyc, e.cyc);
                    chk("rf_wr_addr", bus.rf_addr, e.addr);
                    chk("rf_wr_data", bus.rf_wr_data, e.data);
                end
            end else if (q_wr.size() != 0 && q_wr[0].cyc <= cyc) begin
                chk("rf_wr_pulse", bus.rf_wr_en, 1);
                void'(q_wr.pop_front());
            end

            if (bus.rf_rd_en) begin
                chk("rf_rd_expected", 32'(q_rd.size() != 0), 1);
                if (q_rd.size() != 0) begin
                    e = q_rd.pop_front();
                    chk("rf_rd_cycle", cyc, e.cyc);
                    chk("rf_rd_addr", bus.rf_addr, e.addr);
                end
            end else if (q_rd.size() != 0 && q_rd[0].cyc <= cyc) begin
                chk("rf_rd_pulse", bus.rf_rd_en, 1);
                void'(q_rd.pop_front());
            end

            // Gate window: from the ALU start cycle until the cycle after the result pulse.
            if (alu_vld_prev || rst_prev) exp_gate = 1'b0;
            if (q_alu.size() != 0 && q_alu[0].cyc == cyc) exp_gate = 1'b1;
            if (bus.alu_en) begin
                chk("alu_en_expected", 32'(q_alu.size() != 0), 1);
                if (q_alu.size() != 0) begin
                    e = q_alu.pop_front();
                    chk("alu_en_cycle", cyc, e.cyc);
                    chk("alu_fun", bus.alu_fun, e.addr);
                end
            end else if (q_alu.size() != 0 && q_alu[0].cyc <= cyc) begin
                chk("alu_en_pulse", bus.alu_en, 1);
                void'(q_alu.pop_front());
            end
            chk("clk_gate_en", bus.clk_gate_en, exp_gate);

            if (vld_prev && !rdy_prev && !rst_prev) begin
                chk("tx_hold_vld", bus.tx_d_vld, 1);
                chk("tx_hold_data", bus.tx_p_data, data_prev);
            end
            if (bus.tx_d_vld) begin
                chk("tx_expected", 32'(q_tx.size() != 0), 1);
                if (bus.tx_ready && q_tx.size() != 0) begin
                    chk("tx_byte", bus.tx_p_data, q_tx.pop_front());
                end
            end

            if (bus.cmd_err) begin
                chk("err_expected", 32'(q_err.size() != 0), 1);
                if (q_err.size() != 0) chk("err_cycle", cyc, q_err.pop_front());
            end else if (q_err.size() != 0 && q_err[0] <= cyc) begin
                chk("err_pulse", bus.cmd_err, 1);
                void'(q_err.pop_front());
            end
        end
        rst_prev     = rst;
        alu_vld_prev = bus.alu_out_vld;
        vld_prev     = bus.tx_d_vld;
        rdy_prev     = bus.tx_ready;
        data_prev    = bus.tx_p_data;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int c);
        tick();
        bus.rx_p_data = b;
        bus.rx_d_vld  = 1'b1;
        c = cyc;
        tick();
        bus.rx_d_vld  = 1'b0;
    endtask

    function automatic logic [29:0] all_outs();
        return {bus.rf_addr, bus.rf_wr_data, bus.rf_wr_en, bus.rf_rd_en, bus.alu_fun,
                bus.alu_en, bus.clk_gate_en, bus.tx_p_data, bus.tx_d_vld, bus.cmd_err};
    endfunction

    initial begin
        int c;
        int entry;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.rx_p_data      = '0;
        bus.rx_d_vld       = 1'b0;
        bus.rf_rd_data     = '0;
        bus.rf_rd_data_vld = 1'b0;
        bus.alu_out        = '0;
        bus.alu_out_vld    = 1'b0;
        bus.tx_ready       = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", 32'(all_outs()), 0);
        rst = 1'b0;
        tick();

        // AA: RF write, no TX activity.
        send(CmdRfWr, c);
        send(8'h0B, c);
        send(8'h16, c);
        model_wr(4'hB, 8'h16, c + 1);
        chk("aa_wr_en", bus.rf_wr_en, 1);
        chk("aa_addr", bus.rf_addr, 4'hB);
        chk("aa_data", bus.rf_wr_data, 8'h16);
        repeat (3) tick();

        // BB: read back, TX held while not ready.
        send(CmdRfRd, c);
        send(8'h0B, c);
        q_rd.push_back('{c + 1, 4'hB, 8'h00});
        chk("bb_rd_en", bus.rf_rd_en, 1);
        tick();
        tick();
        q_tx.push_back(8'h16);
        bus.rf_rd_data     = mem[4'hB];
        bus.rf_rd_data_vld = 1'b1;
        tick();
        bus.rf_rd_data_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bb_hold_vld", bus.tx_d_vld, 1);
            chk("bb_hold_data", bus.tx_p_data, 8'h16);
            tick();
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("bb_vld_drop", bus.tx_d_vld, 0);
        tick();

        // CC 5, 6, MUL; a stray frame in ALU_WAIT is dropped with an error.
        bus.tx_ready = 1'b1;
        send(CmdAluOp, c);
        send(8'h05, c);
        model_wr(4'h0, 8'h05, c + 1);
        send(8'h06, c);
        model_wr(4'h1, 8'h06, c + 1);
        send(8'h02, c);
        q_alu.push_back('{c + 1, 4'h2, 8'h00});
        chk("cc_gate_on", bus.clk_gate_en, 1);
        send(8'h77, c);
        q_err.push_back(c + 1);
        q_tx.push_back(8'h1E);
        q_tx.push_back(8'h00);
        tick();
        bus.alu_out     = alu_model(4'h2, mem[0], mem[1]);
        bus.alu_out_vld = 1'b1;
        tick();
        bus.alu_out_vld = 1'b0;
        chk("cc_gate_off", bus.clk_gate_en, 0);
        repeat (4) tick();

        // DD: no operand writes.
        send(CmdAluNoOp, c);
        send(8'h00, c);
        q_alu.push_back('{c + 1, 4'h0, 8'h00});
        q_tx.push_back(8'h03);
        q_tx.push_back(8'h02);
        repeat (3) tick();
        bus.alu_out     = 16'h0203;
        bus.alu_out_vld = 1'b1;
        tick();
        bus.alu_out_vld = 1'b0;
        repeat (4) tick();

        // Unknown opcode in IDLE.
        send(8'h55, c);
        q_err.push_back(c + 1);
        chk("bad_opcode_err", bus.cmd_err, 1);
        repeat (2) tick();

        // RF read timeout.
        send(CmdRfRd, c);
        send(8'h03, c);
        q_rd.push_back('{c + 1, 4'h3, 8'h00});
        entry = c + 1;
        q_err.push_back(entry + TMO + 1);
        while (cyc < entry + TMO + 3) tick();

        // Read response on the very cycle the watchdog expires: the response wins.
        send(CmdRfRd, c);
        send(8'h04, c);
        q_rd.push_back('{c + 1, 4'h4, 8'h00});
        entry = c + 1;
        while (cyc < entry + TMO) tick();
        q_tx.push_back(8'h5A);
        bus.rf_rd_data     = 8'h5A;
        bus.rf_rd_data_vld = 1'b1;
        tick();
        bus.rf_rd_data_vld = 1'b0;
        chk("edge_tx_vld", bus.tx_d_vld, 1);
        repeat (3) tick();

        // Reset while the LSB is waiting: the MSB must never appear.
        bus.tx_ready = 1'b0;
        send(CmdAluNoOp, c);
        send(8'h01, c);
        q_alu.push_back('{c + 1, 4'h1, 8'h00});
        q_tx.push_back(8'hCD);
        q_tx.push_back(8'hAB);
        tick();
        bus.alu_out     = 16'hABCD;
        bus.alu_out_vld = 1'b1;
        tick();
        bus.alu_out_vld = 1'b0;
        chk("lsb_vld", bus.tx_d_vld, 1);
        chk("lsb_data", bus.tx_p_data, 8'hCD);
        rst = 1'b1;
        q_tx.delete();
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs", 32'(all_outs()), 0);
        bus.tx_ready = 1'b1;
        repeat (4) tick();
        send(CmdRfWr, c);
        send(8'h12, c);
        send(8'h99, c);
        model_wr(4'h2, 8'h99, c + 1);
        repeat (3) tick();

        chk("q_wr_empty", q_wr.size(), 0);
        chk("q_rd_empty", q_rd.size(), 0);
        chk("q_alu_empty", q_alu.size(), 0);
        chk("q_tx_empty", q_tx.size(), 0);
        chk("q_err_empty", q_err.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
